// File: rtl/sap_clk_pkg.sv
// Shared types for the SAP-1 clock controller: controller states and the
// speed_sel to period-multiplier table.
package sap_clk_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Index is speed_sel; the auto-run period is BASE_DIV times this value.
    localparam int unsigned SPEED_MULT [4] = '{8, 4, 2, 1};

endpackage

// File: rtl/clock_controller_if.sv
// Button, halt and rate inputs plus the CPU clock-enable and status outputs
// of the SAP-1 clock controller.
interface clock_controller_if;

    logic        step_down;
    logic        runstop_down;
    logic        halt;
    logic [1:0]  speed_sel;
    logic        clk_en;
    logic        running;
    logic        halted;
    logic [15:0] pulse_count;

    modport master (
        output step_down, runstop_down, halt, speed_sel,
        input  clk_en, running, halted, pulse_count
    );

    modport slave (
        input  step_down, runstop_down, halt, speed_sel,
        output clk_en, running, halted, pulse_count
    );

endinterface

// File: rtl/clk_prescaler.sv
// Free-running auto-run prescaler: counts while enabled and flags the cycle
// in which the count has reached the current terminal count.
module clk_prescaler #(
    parameter int unsigned DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] tc,
    output logic                 tick,
    output logic [DIV_WIDTH-1:0] count
);

    // A >= compare lets a shrinking tc fire at once instead of overrunning.
    assign tick = enable && (count >= (tc - DIV_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/clock_controller.sv
// SAP-1 clock controller: single-step / auto-run / halt state machine that
// issues one-cycle CPU clock-enable pulses and counts them.
module clock_controller
    import sap_clk_pkg::*;
#(
    parameter int unsigned BASE_DIV  = 1_500_000,
    parameter int unsigned DIV_WIDTH = 24
) (
    input  logic              clk,
    input  logic              clr,
    clock_controller_if.slave bus
);

    localparam logic [63:0] MAX_TC   = 64'(BASE_DIV) * 64'd8;
    localparam logic [63:0] TC_LIMIT = (64'd1 << DIV_WIDTH) - 64'd1;

    generate
        if (MAX_TC > TC_LIMIT) begin : g_tc_range_check
            $error("clock_controller: BASE_DIV*8 does not fit in DIV_WIDTH bits");
        end
    endgenerate

    state_t                 state;
    state_t                 next_state;
    logic                   clk_en_q;
    logic                   clk_en_next;
    logic                   step_pulse;
    logic [15:0]            pulse_count_q;
    logic [DIV_WIDTH-1:0]   tc;
    logic                   pre_clear;
    logic                   pre_enable;
    logic                   pre_tick;
    logic [DIV_WIDTH-1:0]   pre_count;

    assign tc = DIV_WIDTH'(BASE_DIV * SPEED_MULT[bus.speed_sel]);

    clk_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .clear  (pre_clear),
        .enable (pre_enable),
        .tc     (tc),
        .tick   (pre_tick),
        .count  (pre_count)
    );

    always_comb begin
        next_state = state;
        if (bus.halt) begin
            next_state = HALT;
        end else begin
            case (state)
                STOP:    if (bus.runstop_down) next_state = RUN;
                RUN:     if (bus.runstop_down) next_state = STOP;
                HALT:    next_state = HALT;
                default: next_state = STOP;
            endcase
        end
    end

    // A pulse is only issued if RUN persists across the edge that would emit it.
    always_comb begin
        step_pulse  = (state == STOP) && bus.step_down && !bus.runstop_down && !bus.halt;
        clk_en_next = step_pulse || ((state == RUN) && (next_state == RUN) && pre_tick);
        pre_enable  = (state == RUN);
        pre_clear   = clr || (state != RUN) || (next_state != RUN);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state         <= STOP;
            clk_en_q      <= 1'b0;
            pulse_count_q <= '0;
        end else begin
            state         <= next_state;
            clk_en_q      <= clk_en_next;
            pulse_count_q <= pulse_count_q + {15'd0, clk_en_next};
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && (state != RUN)) begin
            assert (pre_count == '0);
        end
    end

    assign bus.clk_en      = clk_en_q;
    assign bus.running     = (state == RUN);
    assign bus.halted      = (state == HALT);
    assign bus.pulse_count = pulse_count_q;

endmodule

// File: tb/tb_clock_controller.sv
// Self-checking bench for clock_controller with BASE_DIV=2: a vector table
// plus hand sequences for mid-count speed change and pulse counter wrap.
module tb_clock_controller;

    logic clk;
    logic clr;
    int   checks;
    int   failures;

    clock_controller_if bus ();

    clock_controller #(
        .BASE_DIV  (2),
        .DIV_WIDTH (24)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        step;
        logic        runstop;
        logic        halt;
        logic [1:0]  speed;
        logic        clr;
        logic        en;
        logic        run;
        logic        hlt;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic        en;
        logic        run;
        logic        hlt;
        logic [15:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    function automatic vec_t mk(input logic s, input logic r, input logic h,
                                input logic [1:0] sp, input logic c,
                                input logic e, input logic ru, input logic hl,
                                input logic [15:0] n);
        vec_t v;
        v.step = s; v.runstop = r; v.halt = h; v.speed = sp; v.clr = c;
        v.en = e; v.run = ru; v.hlt = hl; v.cnt = n;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v, input string name);
        exp_t e;
        bus.step_down    = v.step;
        bus.runstop_down = v.runstop;
        bus.halt         = v.halt;
        bus.speed_sel    = v.speed;
        clr              = v.clr;
        e.name = name; e.en = v.en; e.run = v.run; e.hlt = v.hlt; e.cnt = v.cnt;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic check_output();
        exp_t e;
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty: no expected entry for DUT output");
        end else begin
            e = exp_q.pop_front();
            if ({bus.clk_en, bus.running, bus.halted, bus.pulse_count} !==
                {e.en, e.run, e.hlt, e.cnt}) begin
                failures++;
                $display("[TB] FAIL %s: got clk_en=%0b running=%0b halted=%0b pulse_count=%04h, expected clk_en=%0b running=%0b halted=%0b pulse_count=%04h",
                         e.name, bus.clk_en, bus.running, bus.halted, bus.pulse_count,
                         e.en, e.run, e.hlt, e.cnt);
            end
        end
    endtask

    task automatic run_cycle(input vec_t v, input string name);
        apply_stimulus(v, name);
        check_output();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running bench, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int unsigned exp_cnt;
        checks   = 0;
        failures = 0;
        bus.step_down    = 1'b0;
        bus.runstop_down = 1'b0;
        bus.halt         = 1'b0;
        bus.speed_sel    = 2'd3;
        clr              = 1'b1;

        //                  step rs halt spd clr | en run hlt cnt
        vecs.push_back(mk(0, 0, 0, 2'd3, 1,   0, 0, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 0, 2'd3, 0,   1, 0, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   0, 0, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   0, 0, 0, 16'd1));
        vecs.push_back(mk(0, 1, 0, 2'd3, 0,   0, 1, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   0, 1, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   1, 1, 0, 16'd2));
        vecs.push_back(mk(1, 0, 0, 2'd3, 0,   0, 1, 0, 16'd2));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   1, 1, 0, 16'd3));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   0, 1, 0, 16'd3));
        vecs.push_back(mk(0, 1, 0, 2'd3, 0,   0, 0, 0, 16'd3));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   0, 0, 0, 16'd3));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   0, 0, 0, 16'd3));
        vecs.push_back(mk(1, 1, 0, 2'd3, 0,   0, 1, 0, 16'd3));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   0, 1, 0, 16'd3));
        vecs.push_back(mk(0, 0, 1, 2'd3, 0,   0, 0, 1, 16'd3));
        vecs.push_back(mk(1, 0, 0, 2'd3, 0,   0, 0, 1, 16'd3));
        vecs.push_back(mk(0, 1, 0, 2'd3, 0,   0, 0, 1, 16'd3));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   0, 0, 1, 16'd3));
        vecs.push_back(mk(0, 0, 0, 2'd3, 1,   0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 0, 1, 2'd3, 0,   0, 0, 1, 16'd0));
        vecs.push_back(mk(0, 0, 0, 2'd3, 1,   0, 0, 0, 16'd0));
        vecs.push_back(mk(0, 1, 0, 2'd3, 0,   0, 1, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   0, 1, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 2'd3, 1,   0, 0, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 2'd3, 0,   0, 0, 0, 16'd0));
        vecs.push_back(mk(0, 1, 0, 2'd2, 0,   0, 1, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 2'd2, 0,   0, 1, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 2'd2, 0,   0, 1, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 2'd2, 0,   0, 1, 0, 16'd0));
        vecs.push_back(mk(0, 0, 0, 2'd2, 0,   1, 1, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 2'd2, 0,   0, 1, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 2'd2, 0,   0, 1, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 2'd2, 0,   0, 1, 0, 16'd1));
        vecs.push_back(mk(0, 0, 0, 2'd2, 0,   1, 1, 0, 16'd2));
        vecs.push_back(mk(0, 1, 0, 2'd2, 0,   0, 0, 0, 16'd2));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(vecs[i], $sformatf("vec%0d", i));
        end

        // Speed increase mid-count: count at 10 of 16, then TC drops to 2.
        run_cycle(mk(0, 0, 0, 2'd0, 1, 0, 0, 0, 16'd0), "speed_clr");
        run_cycle(mk(0, 1, 0, 2'd0, 0, 0, 1, 0, 16'd0), "speed_enter_run");
        for (int i = 0; i < 10; i++) begin
            run_cycle(mk(0, 0, 0, 2'd0, 0, 0, 1, 0, 16'd0), $sformatf("speed_slow%0d", i));
        end
        run_cycle(mk(0, 0, 0, 2'd3, 0, 1, 1, 0, 16'd1), "speed_switch_pulse");
        run_cycle(mk(0, 0, 0, 2'd3, 0, 0, 1, 0, 16'd1), "speed_gap");
        run_cycle(mk(0, 0, 0, 2'd3, 0, 1, 1, 0, 16'd2), "speed_period2");
        run_cycle(mk(0, 0, 0, 2'd3, 0, 0, 1, 0, 16'd2), "speed_gap2");

        // Pulse counter wrap through 65536 single steps.
        run_cycle(mk(0, 0, 0, 2'd3, 1, 0, 0, 0, 16'd0), "wrap_clr");
        exp_cnt = 0;
        for (int i = 0; i < 65535; i++) begin
            exp_cnt++;
            run_cycle(mk(1, 0, 0, 2'd3, 0, 1, 0, 0, 16'(exp_cnt)), "wrap_preload");
        end
        run_cycle(mk(1, 0, 0, 2'd3, 0, 1, 0, 0, 16'h0000), "wrap_rollover");
        run_cycle(mk(0, 0, 0, 2'd3, 0, 0, 0, 0, 16'h0000), "wrap_idle");

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
